// File: rtl/conv_pkg.sv
// Shared constants for the K=3 rate-1/2 convolutional code, used by both the
// encoder and the Viterbi decoder so their generators always agree.
package conv_pkg;

  localparam int K = 3;

  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TAIL1 = 2'd1,
    TAIL2 = 2'd2
  } enc_state_t;

  // Tap vector is {current input, d-1, d-2}; output is the mod-2 sum of taps.
  function automatic logic gen_parity(input logic [K-1:0] g, input logic [K-1:0] taps);
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational symbol generator: (u, sr) -> {g0, g1}. The decoder instantiates
// this same block to build its expected branch symbols.
module conv_sym_gen
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         u,
  input  logic [K-2:0] sr,
  output logic [1:0]   sym
);

  logic [K-1:0] w_taps;

  assign w_taps = {u, sr};
  assign sym[1] = gen_parity(G0, w_taps);
  assign sym[0] = gen_parity(G1, w_taps);

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2 K=3 convolutional encoder with a one-deep output register and
// two zero tail bits per frame so the decoder trellis ends in state 00.
module conv_encoder
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out_sym,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  enc_state_t   r_state;
  enc_state_t   w_state_next;
  logic [K-2:0] r_sr;
  logic [1:0]   r_out_sym;
  logic         r_out_valid;
  logic         r_out_last;

  logic         w_slot_free;
  logic         w_load;
  logic         w_u;
  logic         w_sym_last;
  logic         w_in_ready;
  logic [1:0]   w_sym;

  // The output register can take a new symbol if empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN: begin
        if (in_valid && w_slot_free && in_last) begin
          w_state_next = TAIL1;
        end
      end
      TAIL1: begin
        if (w_slot_free) begin
          w_state_next = TAIL2;
        end
      end
      TAIL2: begin
        if (w_slot_free) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_load     = 1'b0;
    w_u        = 1'b0;
    w_sym_last = 1'b0;
    unique case (r_state)
      RUN: begin
        w_in_ready = w_slot_free;
        w_load     = in_valid && w_slot_free;
        w_u        = in_bit;
      end
      TAIL1: begin
        w_load = w_slot_free;
      end
      TAIL2: begin
        w_load     = w_slot_free;
        w_sym_last = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  conv_sym_gen #(
    .G0(G0),
    .G1(G1)
  ) u_sym_gen (
    .u   (w_u),
    .sr  (r_sr),
    .sym (w_sym)
  );

  // sr only advances on a load, so a stalled output also freezes the trellis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_out_sym   <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_sr        <= {w_u, r_sr[K-2:1]};
      r_out_sym   <= w_sym;
      r_out_valid <= 1'b1;
      r_out_last  <= w_sym_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_sym   = r_out_sym;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
